muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle RV32M multiply/divide unit that sits in the execute stage beside the ALU. It accepts one M-extension operation per start request and iterates a radix-2 shift-add multiplier or restoring divider over XLEN cycles. It holds the pipeline with a stall signal until the result is ready. Special divide cases (divide-by-zero, signed overflow) resolve on a one-cycle fast path.

## Interface
- XLEN, 32, operand/result width; iteration count = XLEN
- i_clk  input  1  core clock, rising-edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_start  input  1  EX stage holds a valid M-extension op (opcode 0110011, funct7 0000001)
- i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_in1  input  XLEN  rs1 operand, already forwarded
- i_in2  input  XLEN  rs2 operand, already forwarded
- i_flush  input  1  branch/exception kill of the EX instruction
- o_stall  output  1  freeze IF/ID/EX; combinational
- o_done  output  1  o_result valid this cycle; registered
- o_result  output  XLEN  final rd value; registered

## Operation
- States: IDLE, CALC, DONE.
- IDLE, i_start=1, i_flush=0: latch funct3 and operand signs, and load |in1| and |in2|.
  - Magnitudes are taken only for signed operands: in1 for MULH/MULHSU/DIV/REM; in2 for MULH/DIV/REM.
  - Normal op: clear the counter and go to CALC.
  - Fast-path op: load o_result and go to DONE.
- Fast path, divide-by-zero (in2==0):
  - DIV/DIVU give all ones (0xFFFFFFFF).
  - REM/REMU give in1 unchanged.
- Fast path, signed overflow (DIV/REM with in1=0x80000000, in2=0xFFFFFFFF):
  - DIV gives 0x80000000.
  - REM gives 0.
- CALC does one iteration per cycle, counter 0..XLEN-1. At counter==XLEN-1 the state goes to DONE.
- Multiply:
  - 2*XLEN accumulator with the multiplier shifted right.
  - Add the shifted multiplicand when the multiplier LSB is 1.
- Divide (restoring):
  - Shift {rem,quot} left by 1.
  - If rem >= divisor: subtract and set quotient LSB to 1.
- Sign fix-up is applied when entering DONE:
  - Product is negated if the sign of in1 differs from the sign of in2 (in2 is always treated as positive for MULHSU).
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Result select:
  - MUL returns product[XLEN-1:0].
  - MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
  - DIV/DIVU return the quotient.
  - REM/REMU return the remainder.
- DONE: o_done=1 and o_result is held. Next state is always IDLE; i_start is ignored in DONE, because it is the same instruction leaving EX.
- i_flush=1 in any state: next state is IDLE and o_done=0. The aborted op never produces o_done, and o_result keeps its previous value.
- o_stall = (state==IDLE && i_start && !i_flush) || state==CALC. o_stall is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- All arithmetic is unsigned on magnitudes; the internal remainder is XLEN+1 bits wide so the compare-subtract is done without overflow.

## Timing
- Reset (async assert): state=IDLE, counter=0, o_done=0, o_result=0, all datapath registers 0. o_stall=0 while i_start=0.
- Normal op: start cycle C0 (o_stall=1), CALC during C1..C32 (o_stall=1), DONE in C33 (o_done=1, o_stall=0).
  - Latency is 33 cycles from start to o_done.
  - The pipeline is stalled for 33 cycles.
- Fast path: start in C0 (o_stall=1), DONE in C1. Latency is 1 cycle.
- Back-to-back ops: the second op's i_start is seen in IDLE on C34 at the earliest. There are no bubble cycles beyond the DONE cycle.
- o_done is a single-cycle pulse per completed op.
- Flush:
  - Flush on the start cycle: the op is not accepted (stall=0) and the state stays IDLE.
  - Flush during CALC: stall drops the following cycle.
- Reset mid-CALC: the FSM returns to IDLE immediately, with no o_done.

## Test plan
- MUL 7*-3 (i_in1=7, i_in2=0xFFFFFFFD) -> o_done in cycle 33, o_result=0xFFFFFFEB, o_stall high for 33 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each completes at cycle 33.
- Fast path: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0. Each gives o_done one cycle after start.
- i_flush asserted in CALC cycle 10 -> IDLE next cycle, o_stall=0, no o_done, o_result unchanged. A following DIVU 9/3 then yields 3.
- i_rst_n pulsed low mid-CALC -> all outputs 0 asynchronously, state IDLE, no o_done after release. Back-to-back MUL then DIV with i_start held through DONE -> exactly two o_done pulses.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide,
// one bit per cycle over XLEN cycles, with a one-cycle path for the special divide cases.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_in1,
  input  logic [XLEN-1:0] i_in2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg1_q, neg1_d, neg2_q, neg2_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [XLEN-1:0]     quot_q, quot_d, rem_q, rem_d, divisor_q, divisor_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  function automatic logic [XLEN-1:0] finalize(
    input logic [2:0]        f3,
    input logic              neg1,
    input logic              neg2,
    input logic [2*XLEN-1:0] acc,
    input logic [XLEN-1:0]   quot,
    input logic [XLEN-1:0]   rem
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q, r;
    prod = (neg1 ^ neg2) ? -acc  : acc;
    q    = (neg1 ^ neg2) ? -quot : quot;
    r    = neg1 ? -rem : rem;
    case (f3)
      3'b000:                 finalize = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: finalize = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         finalize = q;
      default:                finalize = r;
    endcase
  endfunction

  // Operand decode for the accepting cycle
  logic            sgn1_op, sgn2_op, in_neg1, in_neg2, sdiv_op;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] mag1, mag2, fast_val;

  always_comb begin
    sgn1_op  = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
               (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    sgn2_op  = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    sdiv_op  = (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    in_neg1  = sgn1_op && i_in1[XLEN-1];
    in_neg2  = sgn2_op && i_in2[XLEN-1];
    mag1     = in_neg1 ? -i_in1 : i_in1;
    mag2     = in_neg2 ? -i_in2 : i_in2;
    div_zero = i_funct3[2] && (i_in2 == '0);
    div_ovf  = sdiv_op && (i_in1 == INT_MIN) && (i_in2 == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_val = i_funct3[1] ? i_in1 : '1;
    else          fast_val = i_funct3[1] ? '0 : INT_MIN;
  end

  // One iteration of both datapaths; the op latched in f3_q picks which one is used
  logic [2*XLEN-1:0] acc_nx;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic              ge;
  logic [XLEN-1:0]   rem_nx, quot_nx;

  always_comb begin
    acc_nx   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_sh   = {rem_q, quot_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, divisor_q};
    ge       = !rem_diff[XLEN];
    rem_nx   = ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quot_nx  = {quot_q[XLEN-2:0], ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    done_d    = 1'b0;
    o_stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_flush) begin
          o_stall   = 1'b1;
          f3_d      = i_funct3;
          neg1_d    = in_neg1;
          neg2_d    = in_neg2;
          acc_d     = '0;
          mcand_d   = {{XLEN{1'b0}}, mag1};
          mplier_d  = mag2;
          quot_d    = mag1;
          rem_d     = '0;
          divisor_d = mag2;
          cnt_d     = '0;
          if (fast) begin
            result_d = fast_val;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        o_stall  = 1'b1;
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        quot_d   = quot_nx;
        rem_d    = rem_nx;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          result_d = finalize(f3_q, neg1_q, neg2_q, acc_nx, quot_nx, rem_nx);
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A killed instruction never completes and leaves the last result untouched
    if (i_flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign o_done   = done_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: table of ops with hand-computed results and
// latencies, plus flush, reset and back-to-back sequences.
module tb_muldiv_sequencer;

  logic        clk, rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] in1, in2;
  logic        stall, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_funct3(funct3),
    .i_in1(in1), .i_in2(in2), .i_flush(flush),
    .o_stall(stall), .o_done(done), .o_result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 21;
  vec_t tv[NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one op, hold start until done, check latency, stall length, result and pulse width
  task automatic run_vec(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n, scnt;
    n = 0; scnt = 0;
    @(negedge clk);
    start = 1'b1; funct3 = f3; in1 = a; in2 = b;
    forever begin
      #1;
      if (done) break;
      if (stall) scnt++;
      if (n > 45) break;
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, n, lat);
    check({nm, " result"}, result, exp);
    check({nm, " stall cycles"}, scnt, lat);
    check({nm, " stall in done"}, {31'd0, stall}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    #1;
    check({nm, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, pulses, n1, n2;
    logic [31:0] r1, r2, prev;
    logic saw_done;

    tv[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33}; // MUL 7*-3
    tv[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33}; // MULH
    tv[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33}; // MULHU
    tv[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33}; // MULHSU
    tv[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33}; // DIV -7/2
    tv[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33}; // REM -7/2
    tv[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33}; // DIVU
    tv[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33}; // REMU
    tv[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};  // DIVU /0
    tv[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};  // REM /0
    tv[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};  // DIV ovf
    tv[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};  // REM ovf
    tv[12] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         33}; // MULH -1*-1
    tv[13] = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33}; // MULH 7*-3
    tv[14] = '{3'b100, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 33}; // DIV min/2
    tv[15] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33}; // DIVU
    tv[16] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33}; // REMU
    tv[17] = '{3'b100, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1};  // DIV /0
    tv[18] = '{3'b111, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1};  // REMU /0
    tv[19] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33}; // MULHU
    tv[20] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33}; // REM 7/-2

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      run_vec($sformatf("vec%0d", i), tv[i].f3, tv[i].a, tv[i].b, tv[i].exp, tv[i].lat);

    // Flush in CALC cycle 10
    prev = tv[NV-1].exp;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; in1 = 32'd100; in2 = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    check("flush stall in calc", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush stall after", {31'd0, stall}, 32'd0);
    check("flush result kept", result, prev);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("flush no done", {31'd0, saw_done}, 32'd0);
    run_vec("after flush DIVU", 3'b101, 32'd9, 32'd3, 32'd3, 33);

    // Flush on the start cycle: op is never accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; in1 = 32'd3; in2 = 32'd4;
    #1;
    check("start flush stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (done || stall) saw_done = 1'b1;
      @(negedge clk);
    end
    check("start flush idle", {31'd0, saw_done}, 32'd0);
    check("start flush result", result, 32'd3);

    // Asynchronous reset in the middle of CALC
    start = 1'b1; funct3 = 3'b000; in1 = 32'd7; in2 = 32'hFFFF_FFFD;
    repeat (15) @(negedge clk);
    #2;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset result", result, 32'd0);
    check("midreset stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done || stall) saw_done = 1'b1;
    end
    check("midreset no done", {31'd0, saw_done}, 32'd0);

    // Back-to-back MUL then DIV with start held through DONE
    pulses = 0; n1 = -1; n2 = -1; r1 = '0; r2 = '0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; in1 = 32'd7; in2 = 32'hFFFF_FFFD;
    for (n = 0; n < 90; n++) begin
      #1;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          n1 = n; r1 = result;
          funct3 = 3'b100; in1 = 32'hFFFF_FFF9; in2 = 32'd2;
        end else begin
          if (pulses == 2) begin n2 = n; r2 = result; end
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b pulses", pulses, 32'd2);
    check("b2b first cycle", n1, 32'd33);
    check("b2b first result", r1, 32'hFFFF_FFEB);
    check("b2b second cycle", n2, 32'd67);
    check("b2b second result", r2, 32'hFFFF_FFFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
